// File: rtl/conv_feeder.sv
// conv_feeder: raster-order KxK window sequencer over a packed feature map in sync RAM.
// Ports: clk, rstn, start/ready/done ctrl, mem_rd_en/mem_addr/mem_rd_data RAM, en/first_data/last_data/data_o stream; macro CONV_FEEDER_PAD_EN = same padding.
module conv_feeder #(
  parameter int INPUT_NUM = 1,
  parameter int WDP       = 9,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int KSIZE     = 5,
  parameter int ADDR_W    = 10,
  parameter int RD_LAT    = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  output logic                     ready,
  output logic                     done,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [WDP*INPUT_NUM-1:0] mem_rd_data,
  output logic                     en,
  output logic                     first_data,
  output logic                     last_data,
  output logic [WDP*INPUT_NUM-1:0] data_o
);

`ifdef CONV_FEEDER_PAD_EN
  localparam int P  = (KSIZE - 1) / 2;
  localparam int OW = IMG_W;
  localparam int OH = IMG_H;
  localparam int PW = 4;
`else
  localparam int P  = 0;
  localparam int OW = IMG_W - KSIZE + 1;
  localparam int OH = IMG_H - KSIZE + 1;
  localparam int PW = 3;
`endif

  localparam int MXA  = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int MAXD = (MXA > KSIZE) ? MXA : KSIZE;
  localparam int CW   = $clog2(MAXD + 1);
  localparam int LW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   oy_q, oy_d, ox_q, ox_d;
  logic [CW-1:0]   ky_q, ky_d, kx_q, kx_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic            done_q, done_d;
  logic            issue;
  logic [PW-1:0]   flags;
  logic [PW-1:0]   pipe_q [RD_LAT];

  logic kx_end, ky_end, ox_end, oy_end;
  assign kx_end = (kx_q == CW'(KSIZE - 1));
  assign ky_end = (ky_q == CW'(KSIZE - 1));
  assign ox_end = (ox_q == CW'(OW - 1));
  assign oy_end = (oy_q == CW'(OH - 1));

  always_comb begin
    state_d = state_q;
    oy_d    = oy_q;
    ox_d    = ox_q;
    ky_d    = ky_q;
    kx_d    = kx_q;
    lat_d   = lat_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          oy_d    = '0;
          ox_d    = '0;
          ky_d    = '0;
          kx_d    = '0;
        end
      end
      S_RUN: begin
        issue = 1'b1;
        if (kx_end) begin
          kx_d = '0;
          if (ky_end) begin
            ky_d = '0;
            if (ox_end) begin
              ox_d = '0;
              if (oy_end) begin
                oy_d    = '0;
                state_d = S_DRAIN;
                lat_d   = '0;
              end else begin
                oy_d = oy_q + CW'(1);
              end
            end else begin
              ox_d = ox_q + CW'(1);
            end
          end else begin
            ky_d = ky_q + CW'(1);
          end
        end else begin
          kx_d = kx_q + CW'(1);
        end
      end
      S_DRAIN: begin
        // Hold until the last read has come back out of the RAM.
        if (lat_q == LW'(RD_LAT - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tap coordinate; signed so padded taps can go negative.
  int ty, tx;
  always_comb begin
    ty = int'(oy_q) + int'(ky_q) - P;
    tx = int'(ox_q) + int'(kx_q) - P;
    flags = '0;
    flags[0] = issue;
    flags[1] = issue && (kx_q == '0) && (ky_q == '0);
    flags[2] = issue && kx_end && ky_end;
`ifdef CONV_FEEDER_PAD_EN
    begin
      logic in_map;
      in_map = (ty >= 0) && (ty < IMG_H) && (tx >= 0) && (tx < IMG_W);
      mem_rd_en = issue && in_map;
      flags[3]  = issue && !in_map;
    end
`else
    mem_rd_en = issue;
`endif
    mem_addr = mem_rd_en ? ADDR_W'(ty * IMG_W + tx) : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      oy_q    <= '0;
      ox_q    <= '0;
      ky_q    <= '0;
      kx_q    <= '0;
      lat_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      oy_q    <= oy_d;
      ox_q    <= ox_d;
      ky_q    <= ky_d;
      kx_q    <= kx_d;
      lat_q   <= lat_d;
      done_q  <= done_d;
      pipe_q[0] <= flags;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign ready      = (state_q == S_IDLE);
  assign done       = done_q;
  assign en         = pipe_q[RD_LAT-1][0];
  assign first_data = pipe_q[RD_LAT-1][1];
  assign last_data  = pipe_q[RD_LAT-1][2];

`ifdef CONV_FEEDER_PAD_EN
  assign data_o = (en && !pipe_q[RD_LAT-1][3]) ? mem_rd_data : '0;
`else
  assign data_o = en ? mem_rd_data : '0;
`endif

endmodule

// File: tb/tb_conv_feeder.sv
// tb_conv_feeder: two feeders (read latency 1 and 2) on a 4x4 map, kernel 3.
// Scoreboard queues for issued addresses and emitted beats, drained by a negedge monitor.
module tb_conv_feeder;

`ifdef CONV_FEEDER_PAD_EN
  localparam int P  = 1;
  localparam int OW = 4;
  localparam int OH = 4;
`else
  localparam int P  = 0;
  localparam int OW = 2;
  localparam int OH = 2;
`endif
  localparam int K  = 3;
  localparam int NB = OW * OH * K * K;
  localparam int LAT [2] = '{1, 2};

  logic       clk = 1'b0;
  logic       rstn;
  logic       start [2];
  logic       ready [2];
  logic       done [2];
  logic       rd_en [2];
  logic [3:0] addr [2];
  logic [8:0] rdata [2];
  logic       en [2];
  logic       fd [2];
  logic       ld [2];
  logic [8:0] dout [2];
  logic [8:0] r1b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc [2];
  int last_en [2];
  int beats [2];
  logic [8:0] cap [2][NB];
  int bq [2][$];
  int aq [2][$];

`ifdef CONV_FEEDER_PAD_EN
  int hw0 [9]  = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
  int hw15 [9] = '{10, 11, 0, 14, 15, 0, 0, 0, 0};
`else
  int hw0 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int hw1 [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
  int hw3 [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_feeder #(
    .INPUT_NUM(1), .WDP(9), .IMG_W(4), .IMG_H(4),
    .KSIZE(3), .ADDR_W(4), .RD_LAT(1)
  ) u_l1 (
    .clk(clk), .rstn(rstn), .start(start[0]),
    .ready(ready[0]), .done(done[0]),
    .mem_rd_en(rd_en[0]), .mem_addr(addr[0]),
    .mem_rd_data(rdata[0]), .en(en[0]),
    .first_data(fd[0]), .last_data(ld[0]),
    .data_o(dout[0])
  );

  conv_feeder #(
    .INPUT_NUM(1), .WDP(9), .IMG_W(4), .IMG_H(4),
    .KSIZE(3), .ADDR_W(4), .RD_LAT(2)
  ) u_l2 (
    .clk(clk), .rstn(rstn), .start(start[1]),
    .ready(ready[1]), .done(done[1]),
    .mem_rd_en(rd_en[1]), .mem_addr(addr[1]),
    .mem_rd_data(rdata[1]), .en(en[1]),
    .first_data(fd[1]), .last_data(ld[1]),
    .data_o(dout[1])
  );

  // RAM models: word[a] = a, holding the last read when not strobed.
  always @(posedge clk) begin
    if (rd_en[0]) rdata[0] <= {5'b0, addr[0]};
    if (rd_en[1]) r1b <= {5'b0, addr[1]};
    rdata[1] <= r1b;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_pass(input int d);
    for (int oy = 0; oy < OH; oy++)
      for (int ox = 0; ox < OW; ox++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            int ty, tx, dv;
            bit inm;
            ty = oy + ky - P;
            tx = ox + kx - P;
            inm = ty >= 0 && ty < 4 && tx >= 0 && tx < 4;
            dv = inm ? ty * 4 + tx : 0;
            if (inm) aq[d].push_back(ty * 4 + tx);
            bq[d].push_back((int'(ky == 0 && kx == 0) << 10) |
                            (int'(ky == K-1 && kx == K-1) << 9) | dv);
          end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int e;
      if (!rstn) begin
        beats[d] = 0;
      end else begin
        if (rd_en[d]) begin
          if (aq[d].size() == 0) chk("addr_unexpected", int'(addr[d]), -1);
          else begin
            e = aq[d].pop_front();
            chk("mem_addr", int'(addr[d]), e);
          end
        end
        if (en[d]) begin
          if (bq[d].size() == 0) chk("beat_unexpected", int'(dout[d]), -1);
          else begin
            e = bq[d].pop_front();
            chk("beat_flags_data", int'({fd[d], ld[d], dout[d]}), e);
          end
          if (beats[d] == 0) chk("first_en_latency", cyc - start_cyc[d], 1 + LAT[d]);
          else chk("beat_gap", cyc - last_en[d], 1);
          if (beats[d] < NB) cap[d][beats[d]] = dout[d];
          beats[d]++;
          last_en[d] = cyc;
        end
        if (done[d]) begin
          chk("done_timing", cyc - last_en[d], 1);
          chk("beat_count", beats[d], NB);
          beats[d] = 0;
        end
      end
    end
  end

  task automatic wait_done(input int d);
    bit got = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      if (done[d]) got = 1;
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic hand(input int d);
    for (int i = 0; i < 9; i++) begin
`ifdef CONV_FEEDER_PAD_EN
      chk("win0", int'(cap[d][i]), hw0[i]);
      chk("win15", int'(cap[d][135+i]), hw15[i]);
`else
      chk("win0", int'(cap[d][i]), hw0[i]);
      chk("win1", int'(cap[d][9+i]), hw1[i]);
      chk("win3", int'(cap[d][27+i]), hw3[i]);
`endif
    end
    chk("beatq_empty", bq[d].size(), 0);
    chk("addrq_empty", aq[d].size(), 0);
  endtask

  task automatic kick(input int d);
    push_pass(d);
    start[d] = 1'b1;
    start_cyc[d] = cyc;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic seq(input int d);
    kick(d);
    repeat (10) @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    wait_done(d);
    hand(d);
    kick(d);
    wait_done(d);
    hand(d);
  endtask

  task automatic clean(input int d);
    kick(d);
    wait_done(d);
    hand(d);
  endtask

  task automatic rst_vals(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_ready"}, int'(ready[d]), 1);
      chk({tag, "_en"}, int'(en[d]), 0);
      chk({tag, "_done"}, int'(done[d]), 0);
      chk({tag, "_rd_en"}, int'(rd_en[d]), 0);
      chk({tag, "_data"}, int'(dout[d]), 0);
    end
  endtask

  initial begin
    int act;
    bit hit;
    rstn = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_vals("reset");
    rstn = 1'b1;
    act = 0;
    repeat (10) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        if (en[d] || rd_en[d] || done[d] || !ready[d]) act++;
    end
    chk("idle_activity", act, 0);

    fork
      seq(0);
      seq(1);
    join

    repeat (3) @(negedge clk);
    push_pass(0);
    push_pass(1);
    start[0] = 1'b1;
    start[1] = 1'b1;
    start_cyc[0] = cyc;
    start_cyc[1] = cyc;
    @(negedge clk);
    start[0] = 1'b0;
    start[1] = 1'b0;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (beats[0] >= 20) hit = 1;
    end
    if (!hit) chk("beat20_timeout", 0, 1);
    rstn = 1'b0;
    #1;
    rst_vals("midreset");
    for (int d = 0; d < 2; d++) begin
      bq[d].delete();
      aq[d].delete();
    end
    @(negedge clk);
    rstn = 1'b1;
    act = 0;
    repeat (6) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        if (done[d] || en[d]) act++;
    end
    chk("post_reset_quiet", act, 0);

    fork
      clean(0);
      clean(1);
    join

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
